// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length encoding, per-length schedule geometry and
// the GF(2^8) doubling used to advance the round constant.
package aes_pkg;

  localparam int unsigned AES_WORD = 32;

  typedef enum logic [1:0] {
    KeyLen128  = 2'd0,
    KeyLen192  = 2'd1,
    KeyLen256  = 2'd2,
    KeyLenRsvd = 2'd3
  } key_len_e;

  // Reserved encoding behaves as AES-128 in all three helpers.
  function automatic logic [3:0] nk_of(input key_len_e kl);
    case (kl)
      KeyLen192: return 4'd6;
      KeyLen256: return 4'd8;
      default:   return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input key_len_e kl);
    case (kl)
      KeyLen192: return 4'd12;
      KeyLen256: return 4'd14;
      default:   return 4'd10;
    endcase
  endfunction

  function automatic logic [5:0] nwords_of(input key_len_e kl);
    case (kl)
      KeyLen192: return 6'd52;
      KeyLen256: return 6'd60;
      default:   return 6'd44;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in and one byte out, looked up from a constant table.
module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  // Entry 0x00 sits in the top byte, so the lookup counts down from bit 2047.
  localparam logic [2047:0] SboxTab = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] base;

  assign base   = 11'd2047 - {data_i, 3'b000};
  assign data_o = SboxTab[base -: 8];

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128/192/256 key schedule: one 32-bit word per clock into a word buffer, then
// round keys through a registered read port. Define AES_KEYEXP_DEC_EN to add the rd_dec port.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 60
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [0:255] key,
`ifdef AES_KEYEXP_DEC_EN
  input  logic         rd_dec,
`endif
  output logic         busy,
  output logic         done,
  output logic         ready,
  output logic [3:0]   rounds,
  input  logic [3:0]   rd_idx,
  output logic [0:127] rd_key
);

  localparam int unsigned IdxW = $clog2(MAX_WORDS);

  typedef enum logic [0:0] {StIdle, StExpand} state_e;

  state_e               state_q, state_d;
  key_len_e             kl;
  logic [3:0]           nk_new, nr_new;
  logic [2:0]           nkm1_new, nkm1_q, j_q;
  logic [IdxW-1:0]      last_new, last_q, i_q;
  logic [7:0]           rcon_q;
  logic                 go, step;
  logic [255:0]         key_flat;
  logic [AES_WORD-1:0]  key_w [8];
  // win_q[k] holds w[i-1-k]; only the first Nk entries matter.
  logic [AES_WORD-1:0]  win_q [8];
  logic [AES_WORD-1:0]  sched_q [MAX_WORDS];
  logic [AES_WORD-1:0]  prev, oldw, sub_in, sub_out, temp, new_word;
  logic [3:0]           rd_eff;
  logic [IdxW-1:0]      rd_base;

  assign kl       = key_len_e'(key_len);
  assign nk_new   = nk_of(kl);
  assign nr_new   = nr_of(kl);
  assign nkm1_new = 3'(nk_new - 4'd1);
  assign last_new = IdxW'(nwords_of(kl) - 6'd1);
  assign go       = (state_q == StIdle) && start;
  assign step     = (state_q == StExpand);
  assign busy     = step;
  assign key_flat = key;

  always_comb begin
    for (int m = 0; m < 8; m++) key_w[m] = key_flat[255 - 32*m -: 32];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StExpand;
      StExpand: if (i_q == last_q) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign prev   = win_q[0];
  assign oldw   = win_q[nkm1_q];
  assign sub_in = (j_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

  // One SubWord shared by the RotWord step and the extra AES-256 substitution.
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .data_i (sub_in[8*g +: 8]),
      .data_o (sub_out[8*g +: 8])
    );
  end

  always_comb begin
    temp = prev;
    if (j_q == 3'd0) begin
      temp = sub_out ^ {rcon_q, 24'h0};
    end else if (nkm1_q == 3'd7 && j_q == 3'd4) begin
      temp = sub_out;
    end
    new_word = oldw ^ temp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      done    <= 1'b0;
      ready   <= 1'b0;
      rounds  <= 4'd0;
      nkm1_q  <= 3'd0;
      j_q     <= 3'd0;
      i_q     <= '0;
      last_q  <= '0;
      rcon_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      if (go) begin
        nkm1_q <= nkm1_new;
        rounds <= nr_new;
        last_q <= last_new;
        i_q    <= IdxW'(nk_new);
        j_q    <= 3'd0;
        rcon_q <= 8'h01;
        ready  <= 1'b0;
      end else if (step) begin
        i_q <= i_q + IdxW'(1);
        j_q <= (j_q == nkm1_q) ? 3'd0 : j_q + 3'd1;
        if (j_q == 3'd0) rcon_q <= xtime(rcon_q);
        if (i_q == last_q) begin
          ready <= 1'b1;
          done  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && go) begin
      for (int k = 0; k < 8; k++) begin
        if (3'(k) <= nkm1_new) win_q[k] <= key_w[nkm1_new - 3'(k)];
        if (4'(k) < nk_new) sched_q[k] <= key_w[k];
      end
    end else if (!rst && step) begin
      win_q[0] <= new_word;
      for (int k = 1; k < 8; k++) win_q[k] <= win_q[k-1];
      sched_q[i_q] <= new_word;
    end
  end

`ifdef AES_KEYEXP_DEC_EN
  assign rd_eff = rd_dec ? rounds - rd_idx : rd_idx;
`else
  assign rd_eff = rd_idx;
`endif
  assign rd_base = IdxW'({rd_eff, 2'b00});

  // The range check uses the raw index, before any decryption-order mapping.
  always_ff @(posedge clk) begin
    if (rst || rd_idx > rounds) begin
      rd_key <= '0;
    end else begin
      rd_key <= {sched_q[rd_base], sched_q[rd_base + IdxW'(1)],
                 sched_q[rd_base + IdxW'(2)], sched_q[rd_base + IdxW'(3)]};
    end
  end

endmodule
